hs32_decode_q: RTL and testbench

//  Buffered, parametrised HS32 decode stage between fetch and execute.
//  - Accepts 32-bit instruction words from fetch over a reqd/ackd handshake.
//  - Decodes each word into ALU op, immediate, up to three register fields and a control word.
//  - Queues decoded entries in a DEPTH-entry FIFO; presents them to execute over a vald/rdye handshake.
//  - Adds pipeline flush and illegal-opcode flagging.

---
 rtl/hs32_decode_pkg.sv | 77 +++++++
 rtl/hs32_sfifo.sv | 52 +++++
 rtl/hs32_decode_q.sv | 78 +++++++
 tb/tb_hs32_decode_q.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_decode_pkg.sv
// Shared definitions for the HS32 decode stage: instruction classes, control-word
// bit positions and the pure combinational instruction decoder.
package hs32_decode_pkg;

    typedef enum logic [1:0] {
        CLS_ALU_REG = 2'b00,
        CLS_ALU_IMM = 2'b01,
        CLS_MEM     = 2'b10,
        CLS_BRANCH  = 2'b11
    } insn_class_e;

    localparam int CTL_REGWR   = 0;
    localparam int CTL_USEIMM  = 1;
    localparam int CTL_LOAD    = 2;
    localparam int CTL_STORE   = 3;
    localparam int CTL_BRANCH  = 4;
    localparam int CTL_COND_LO = 5;
    localparam int CTL_COND_HI = 8;
    localparam int CTL_ILLEGAL = 9;
    localparam int CTL_BASE_W  = 10;

    // Native ISA widths; the top resizes fields to its parameters.
    typedef struct packed {
        logic [2:0]            aluop;
        logic [15:0]           imm;
        logic [3:0]            rs;
        logic [3:0]            rs2;
        logic [3:0]            rd;
        logic [CTL_BASE_W-1:0] ctl;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] word);
        decoded_t   d;
        logic [7:0] op;
        logic       illegal;
        op      = word[31:24];
        d       = '0;
        d.rd    = word[23:20];
        d.rs    = word[19:16];
        d.rs2   = word[15:12];
        d.imm   = word[15:0];
        illegal = 1'b0;
        case (insn_class_e'(op[7:6]))
            CLS_ALU_REG: begin
                d.aluop            = op[2:0];
                d.ctl[CTL_REGWR]   = 1'b1;
                illegal            = (op[5:3] != 3'b000);
            end
            CLS_ALU_IMM: begin
                d.aluop            = op[2:0];
                d.ctl[CTL_REGWR]   = 1'b1;
                d.ctl[CTL_USEIMM]  = 1'b1;
                illegal            = (op[5:3] != 3'b000);
            end
            CLS_MEM: begin
                d.ctl[CTL_USEIMM]  = 1'b1;
                d.ctl[CTL_STORE]   = op[5];
                d.ctl[CTL_LOAD]    = ~op[5];
                d.ctl[CTL_REGWR]   = ~op[5];
                illegal            = (op[4:0] != 5'b00000);
            end
            default: begin
                d.ctl[CTL_BRANCH]  = 1'b1;
                d.ctl[CTL_USEIMM]  = 1'b1;
                d.ctl[CTL_COND_HI:CTL_COND_LO] = op[5:2];
            end
        endcase
        // Illegal words still travel down the pipe so execute can trap on them.
        if (illegal) begin
            d.aluop            = '0;
            d.ctl              = '0;
            d.ctl[CTL_ILLEGAL] = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/hs32_sfifo.sv
// Synchronous FIFO with occupancy count, flush, and zero read-out while empty.
module hs32_sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage has no reset; count gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: non-blocking assignments keep every register update based on pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/hs32_decode_q.sv
// HS32 decode stage: decodes fetched words and queues them for execute.
module hs32_decode_q
    import hs32_decode_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 4,
    parameter int CTL_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instd,
    output logic              reqd,
    input  logic              ackd,
    input  logic              flush,
    output logic [2:0]        aluop,
    output logic [IMM_W-1:0]  imm,
    output logic [REG_AW-1:0] regsrc,
    output logic [REG_AW-1:0] regsrc2,
    output logic [REG_AW-1:0] regdst,
    output logic [CTL_W-1:0]  ctlsig,
    output logic              vald,
    input  logic              rdye
);
    typedef struct packed {
        logic [2:0]        aluop;
        logic [IMM_W-1:0]  imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [CTL_W-1:0]  ctl;
    } entry_t;

    decoded_t dec;
    entry_t   in_entry;
    entry_t   head_entry;
    logic     full;
    logic     empty;

    assign dec = decode(instd);

    always_comb begin
        in_entry       = '0;
        in_entry.aluop = dec.aluop;
        in_entry.imm   = IMM_W'($signed(dec.imm));
        in_entry.rs    = REG_AW'(dec.rs);
        in_entry.rs2   = REG_AW'(dec.rs2);
        in_entry.rd    = REG_AW'(dec.rd);
        in_entry.ctl   = CTL_W'(dec.ctl);
    end

    // Handshake depends only on registered occupancy, never on ackd or rdye.
    assign reqd = !reset && !full;

    hs32_sfifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (reqd && ackd),
        .wr_data (in_entry),
        .pop     (rdye),
        .rd_data (head_entry),
        .full    (full),
        .empty   (empty)
    );

    assign vald    = !empty;
    assign aluop   = head_entry.aluop;
    assign imm     = head_entry.imm;
    assign regsrc  = head_entry.rs;
    assign regsrc2 = head_entry.rs2;
    assign regdst  = head_entry.rd;
    assign ctlsig  = head_entry.ctl;

endmodule

// File: tb/tb_hs32_decode_q.sv
// Scoreboard bench for hs32_decode_q: stimulus pushes expected entries, a monitor pops on consume.
module tb_hs32_decode_q;
    localparam int DEPTH  = 2;
    localparam int IMM_W  = 32;
    localparam int REG_AW = 4;
    localparam int CTL_W  = 16;

    typedef struct packed {
        logic [2:0]  aluop;
        logic [31:0] imm;
        logic [3:0]  rs;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [15:0] ctl;
    } exp_t;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       instd = '0;
    logic              ackd  = 1'b0;
    logic              flush = 1'b0;
    logic              rdye  = 1'b0;
    logic              reqd;
    logic [2:0]        aluop;
    logic [IMM_W-1:0]  imm;
    logic [REG_AW-1:0] regsrc;
    logic [REG_AW-1:0] regsrc2;
    logic [REG_AW-1:0] regdst;
    logic [CTL_W-1:0]  ctlsig;
    logic              vald;

    exp_t        exp_q[$];
    logic [31:0] vec_word [10];
    exp_t        vec_exp  [10];
    int          checks = 0;
    int          errors = 0;
    int          k;

    hs32_decode_q #(
        .DEPTH(DEPTH), .IMM_W(IMM_W), .REG_AW(REG_AW), .CTL_W(CTL_W)
    ) dut (
        .clk(clk), .reset(reset), .instd(instd), .reqd(reqd), .ackd(ackd),
        .flush(flush), .aluop(aluop), .imm(imm), .regsrc(regsrc),
        .regsrc2(regsrc2), .regdst(regdst), .ctlsig(ctlsig), .vald(vald),
        .rdye(rdye)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] a, input logic [31:0] i, input logic [3:0] s,
                                input logic [3:0] s2, input logic [3:0] d, input logic [15:0] c);
        exp_t e;
        e.aluop = a; e.imm = i; e.rs = s; e.rs2 = s2; e.rd = d; e.ctl = c;
        return e;
    endfunction

    // Monitor: every consumed head entry is compared against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && !flush && vald && rdye) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got ctlsig 0x%0h with empty scoreboard", ctlsig);
            end else begin
                e = exp_q.pop_front();
                check("head_entry", {aluop, imm, regsrc, regsrc2, regdst, ctlsig}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx);
        instd = vec_word[idx];
        ackd  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (reqd) begin
                exp_q.push_back(vec_exp[idx]);
                tick();
                ackd  = 1'b0;
                instd = '0;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: vector %0d never accepted", idx);
        ackd = 1'b0;
    endtask

    task automatic drain();
        rdye = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
        tick();
        check("drain_left", exp_q.size(), 0);
        @(negedge clk);
        check("drain_vald", vald, 0);
        tick();
    endtask

    initial begin
        vec_word[0] = 32'h0134_5000; vec_exp[0] = mk(3'd1, 32'h0000_5000, 4'h4, 4'h5, 4'h3, 16'h0001);
        vec_word[1] = 32'h4212_FFFE; vec_exp[1] = mk(3'd2, 32'hFFFF_FFFE, 4'h2, 4'hF, 4'h1, 16'h0003);
        vec_word[2] = 32'hA056_0008; vec_exp[2] = mk(3'd0, 32'h0000_0008, 4'h6, 4'h0, 4'h5, 16'h000A);
        vec_word[3] = 32'h8078_0004; vec_exp[3] = mk(3'd0, 32'h0000_0004, 4'h8, 4'h0, 4'h7, 16'h0007);
        vec_word[4] = 32'hDC00_0010; vec_exp[4] = mk(3'd0, 32'h0000_0010, 4'h0, 4'h0, 4'h0, 16'h00F2);
        vec_word[5] = 32'h08AB_C123; vec_exp[5] = mk(3'd0, 32'hFFFF_C123, 4'hB, 4'hC, 4'hA, 16'h0200);
        vec_word[6] = 32'h0FAB_C123; vec_exp[6] = mk(3'd0, 32'hFFFF_C123, 4'hB, 4'hC, 4'hA, 16'h0200);
        vec_word[7] = 32'h8100_0000; vec_exp[7] = mk(3'd0, 32'h0000_0000, 4'h0, 4'h0, 4'h0, 16'h0200);
        vec_word[8] = 32'h47E9_A7F0; vec_exp[8] = mk(3'd7, 32'hFFFF_A7F0, 4'h9, 4'hA, 4'hE, 16'h0003);
        vec_word[9] = 32'hC300_0000; vec_exp[9] = mk(3'd0, 32'h0000_0000, 4'h0, 4'h0, 4'h0, 16'h0012);

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("reset_reqd", reqd, 0);
        check("reset_vald", vald, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_reqd", reqd, 1);
        check("post_reset_vald", vald, 0);
        check("post_reset_ctlsig", ctlsig, 0);
        check("post_reset_imm", imm, 0);
        tick();

        // Single word, one-cycle latency
        rdye = 1'b1;
        send(0);
        @(negedge clk);
        check("latency_vald", vald, 1);
        tick();
        drain();

        // Every decode class, legal and illegal
        for (int i = 1; i < 10; i++) send(i);
        drain();

        // Fill with ackd held and execute stalled
        rdye = 1'b0;
        k    = 0;
        ackd = 1'b1;
        for (int c = 0; c < 6; c++) begin
            instd = vec_word[k];
            @(negedge clk);
            if (reqd) begin
                exp_q.push_back(vec_exp[k]);
                k++;
            end
            tick();
        end
        ackd = 1'b0;
        check("full_accepts", k, DEPTH);
        @(negedge clk);
        check("full_reqd", reqd, 0);
        check("full_vald", vald, 1);
        tick();

        // One pop reopens the input
        rdye = 1'b1;
        tick();
        rdye = 1'b0;
        @(negedge clk);
        check("pop_reqd", reqd, 1);
        tick();

        // Push and pop together at count 1
        rdye = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instd = vec_word[6 + i];
            ackd  = 1'b1;
            @(negedge clk);
            check("stream_reqd", reqd, 1);
            check("stream_vald", vald, 1);
            exp_q.push_back(vec_exp[6 + i]);
            tick();
        end
        ackd = 1'b0;
        drain();

        // Flush at count 2 overrides the same-cycle pop
        rdye = 1'b0;
        send(2);
        send(3);
        instd = vec_word[4];
        ackd  = 1'b1;
        rdye  = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ackd  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_vald", vald, 0);
        check("flush_reqd", reqd, 1);
        check("flush_ctlsig", ctlsig, 0);
        tick();
        tick();
        @(negedge clk);
        check("flush_nothing_queued", vald, 0);
        tick();

        // Flush at count 1 overrides the same-cycle push
        rdye = 1'b0;
        send(5);
        instd = vec_word[6];
        ackd  = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ackd  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_push_vald", vald, 0);
        check("flush_push_regdst", regdst, 0);
        tick();

        // Reset with the queue full
        send(7);
        send(8);
        @(negedge clk);
        check("prereset_full_reqd", reqd, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_reqd", reqd, 0);
        tick();
        exp_q.delete();
        @(negedge clk);
        check("reset_mid_vald", vald, 0);
        check("reset_mid_imm", imm, 0);
        check("reset_mid_ctlsig", ctlsig, 0);
        check("reset_mid_regdst", regdst, 0);
        check("reset_mid_aluop", aluop, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_release_reqd", reqd, 1);
        check("reset_release_vald", vald, 0);
        tick();

        // Normal operation resumes after reset
        rdye = 1'b1;
        send(1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
